// File: rtl/div9x4_seq.sv
// Iterative unsigned restoring divider, one quotient bit per clock.
// Valid/ready handshakes on both sides; divide-by-zero yields all-ones quotient.
module div9x4_seq #(
  parameter int DW = 9,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_zero
);

  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [DW-1:0] dvd_reg;
  logic [VW-1:0] dvs_reg;
  logic [VW:0]   prem_reg;
  logic [CW-1:0] cnt_reg;
  logic          zero_reg;

  logic [VW+1:0] shifted;
  logic [VW+1:0] trial;
  logic          q_bit;
  logic [VW:0]   prem_next;
  logic [DW-1:0] dvd_next;

  // The shifted partial remainder always fits in VW+1 bits, so the top bit
  // of the trial difference is a clean borrow.
  always_comb begin
    shifted   = {prem_reg, dvd_reg[DW-1]};
    trial     = shifted - {2'b00, dvs_reg};
    q_bit     = ~trial[VW+1];
    prem_next = q_bit ? trial[VW:0] : shifted[VW:0];
    dvd_next  = {dvd_reg[DW-2:0], q_bit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      cnt_reg   <= '0;
      dvd_reg   <= '0;
      dvs_reg   <= '0;
      prem_reg  <= '0;
      zero_reg  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            dvd_reg  <= dividend;
            dvs_reg  <= divisor;
            prem_reg <= '0;
            cnt_reg  <= CW'(DW - 1);
            zero_reg <= (divisor == '0);
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end
        CALC: begin
          dvd_reg  <= dvd_next;
          prem_reg <= prem_next;
          cnt_reg  <= cnt_reg - CW'(1);
          if (cnt_reg == '0) begin
            state     <= DONE;
            out_valid <= 1'b1;
            quotient  <= zero_reg ? '1 : dvd_next;
            remainder <= zero_reg ? '0 : prem_next[VW-1:0];
            div_zero  <= zero_reg;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div9x4_seq.sv
// Scoreboard bench for div9x4_seq: directed cases, backpressure, reset abort
// and an exhaustive back-to-back sweep of all operand pairs.
`timescale 1ns/1ps
module tb_div9x4_seq;
  localparam int DW = 9;
  localparam int VW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] dividend;
  logic [VW-1:0] divisor;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] quotient;
  logic [VW-1:0] remainder;
  logic          div_zero;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_acc = -1;
  logic check_spacing = 1'b0;

  logic [DW+VW:0] exp_q[$];
  int             acc_q[$];

  div9x4_seq #(.DW(DW), .VW(VW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .dividend(dividend), .divisor(divisor),
    .out_valid(out_valid), .out_ready(out_ready),
    .quotient(quotient), .remainder(remainder), .div_zero(div_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0d expected=%0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [DW+VW:0] model(input int a, input int d);
    if (d == 0) return {9'd511, 4'd0, 1'b1};
    return {9'(a / d), 4'(a % d), 1'b0};
  endfunction

  // Output monitor: latency, hold under backpressure, result and post-drain ready.
  logic           prev_valid = 1'b0;
  logic           drained = 1'b0;
  logic [DW+VW:0] held;
  always @(negedge clk) begin
    if (rst) begin
      prev_valid = 1'b0;
      drained = 1'b0;
    end else begin
      if (drained) begin
        check_eq("ready_after_drain", {30'd0, out_valid, in_ready}, 32'd1);
        drained = 1'b0;
      end
      if (out_valid) begin
        check_eq("busy_ready", in_ready, 0);
        if (!prev_valid) begin
          held = {quotient, remainder, div_zero};
          if (acc_q.size() == 0) check_eq("unexpected_result", out_valid, 0);
          else check_eq("latency", cyc - acc_q[0], DW);
        end else begin
          check_eq("hold", {quotient, remainder, div_zero}, held);
        end
        if (out_ready) begin
          if (exp_q.size() > 0) begin
            check_eq("result", {quotient, remainder, div_zero}, exp_q.pop_front());
            void'(acc_q.pop_front());
          end
          drained = 1'b1;
        end
      end
      prev_valid = out_valid;
    end
  end

  task automatic send(input int a, input int d);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      check_eq("accept_timeout", in_ready, 1);
      return;
    end
    in_valid = 1'b1;
    dividend = DW'(a);
    divisor  = VW'(d);
    @(negedge clk);
    exp_q.push_back(model(a, d));
    acc_q.push_back(cyc);
    if (check_spacing && last_acc >= 0) check_eq("spacing", cyc - last_acc, DW + 2);
    last_acc = cyc;
    in_valid = 1'b0;
    dividend = DW'($urandom);
    divisor  = VW'($urandom);
  endtask

  task automatic wait_empty();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) check_eq("drain_timeout", exp_q.size(), 0);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    dividend = '0; divisor = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_outputs", {quotient, remainder, div_zero}, 0);
    rst = 1'b0;

    // Basic divide and extremes
    send(300, 7);
    wait_empty();
    send(511, 1);
    send(5, 15);
    send(0, 9);
    wait_empty();

    // Divide by zero, then a normal op
    send(100, 0);
    send(100, 10);
    wait_empty();

    // Backpressure with ignored in_valid pulses while busy
    out_ready = 1'b0;
    send(150, 4);
    repeat (3) begin
      @(negedge clk);
      in_valid = 1'b1; dividend = DW'($urandom); divisor = VW'($urandom);
      @(negedge clk);
      in_valid = 1'b0;
    end
    begin
      int n = 0;
      while (!out_valid && n < 50) begin
        @(negedge clk);
        n++;
      end
      check_eq("bp_valid_seen", out_valid, 1);
    end
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(77, 5);
    wait_empty();

    // Reset in the middle of CALC discards the pending result
    send(200, 3);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    exp_q.delete();
    acc_q.delete();
    @(negedge clk);
    check_eq("abort_in_ready", in_ready, 1);
    check_eq("abort_out_valid", out_valid, 0);
    check_eq("abort_outputs", {quotient, remainder, div_zero}, 0);
    rst = 1'b0;
    send(200, 3);
    wait_empty();

    // Exhaustive back-to-back sweep
    check_spacing = 1'b1;
    last_acc = -1;
    for (int a = 0; a < 512; a++)
      for (int d = 0; d < 16; d++)
        send(a, d);
    wait_empty();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
